serializer: RTL and testbench

SERIALIZER -- requirements
Module: serializer

---
 rtl/serializer.sv | 47 ++++
 tb/tb_serializer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// Parallel-to-serial converter: samples data_in every WIDTH clocks and shifts it out one bit per clock.
// Frames run back-to-back with no gaps. data_out comes straight from a flip-flop.
module serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic             data_out
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    idx;
  logic             next_bit;

  // The frame-start bit comes from data_in directly, so the first bit has no extra latency.
  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    idx      = MSB_FIRST ? (LAST - cnt) : cnt;
    next_bit = sreg[idx];
    if (cnt == '0) begin
      next_bit = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      sreg     <= '0;
      data_out <= 1'b0;
    end else begin
      // The explicit wrap keeps cnt below WIDTH when WIDTH is not a power of two.
      cnt      <= (cnt == LAST) ? '0 : cnt + CW'(1);
      data_out <= next_bit;
      if (cnt == '0) begin
        sreg <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: three instances (8/MSB, 8/LSB, 5/MSB) against a bit-queue model,
// plus constant frame tables and hand-written reset corner cases.
module tb_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din8;
  logic [4:0] din5;
  logic       out8m, out8l, out5;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: at each frame start, the whole word is unrolled into a queue of bits in send order.
  // Then one bit is popped per clock edge.
  bit q8m[$];
  bit q8l[$];
  bit q5[$];
  bit exp8m, exp8l, exp5;

  typedef struct {
    logic [7:0] din;
    logic [7:0] seq_msb;  // emission order, leftmost bit first
    logic [7:0] seq_lsb;
  } vec_t;

  vec_t vecs[5];

  serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8m (.clk(clk), .rst(rst), .data_in(din8), .data_out(out8m));
  serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8l (.clk(clk), .rst(rst), .data_in(din8), .data_out(out8l));
  serializer #(.WIDTH(5), .MSB_FIRST(1'b1)) dut5  (.clk(clk), .rst(rst), .data_in(din5), .data_out(out5));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_flush();
    q8m.delete();
    q8l.delete();
    q5.delete();
    exp8m = 1'b0;
    exp8l = 1'b0;
    exp5  = 1'b0;
  endtask

  // One clock edge: advance the model with the pre-edge inputs, then compare all instances 1 time unit later.
  task automatic tick();
    logic [7:0] s8;
    logic [4:0] s5;
    s8 = din8;
    s5 = din5;
    @(posedge clk);
    if (rst) begin
      if (q8m.size() == 0) for (int i = 7; i >= 0; i--) q8m.push_back(s8[i]);
      if (q8l.size() == 0) for (int i = 0; i <= 7; i++) q8l.push_back(s8[i]);
      if (q5.size() == 0)  for (int i = 4; i >= 0; i--) q5.push_back(s5[i]);
      exp8m = q8m.pop_front();
      exp8l = q8l.pop_front();
      exp5  = q5.pop_front();
    end else begin
      model_flush();
    end
    #1;
    check("out8_msb", 32'(out8m), 32'(exp8m));
    check("out8_lsb", 32'(out8l), 32'(exp8l));
    check("out5_msb", 32'(out5), 32'(exp5));
    check("cnt5_range", 32'(dut5.cnt <= 3'd4), 32'd1);
  endtask

  // Reset pulse placed between clock edges; outputs must drop without any edge.
  task automatic async_reset_pulse();
    #2 rst = 1'b0;
    #1;
    model_flush();
    check("async_rst_out8m", 32'(out8m), 32'd0);
    check("async_rst_out8l", 32'(out8l), 32'd0);
    check("async_rst_out5", 32'(out5), 32'd0);
    check("async_rst_cnt8", 32'(dut8m.cnt), 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    logic [15:0] seq16;
    logic [7:0]  sq;

    vecs[0] = '{din: 8'b10011101, seq_msb: 8'b10011101, seq_lsb: 8'b10111001};
    vecs[1] = '{din: 8'hA5,       seq_msb: 8'b10100101, seq_lsb: 8'b10100101};
    vecs[2] = '{din: 8'h01,       seq_msb: 8'b00000001, seq_lsb: 8'b10000000};
    vecs[3] = '{din: 8'hF0,       seq_msb: 8'b11110000, seq_lsb: 8'b00001111};
    vecs[4] = '{din: 8'h3C,       seq_msb: 8'b00111100, seq_lsb: 8'b00111100};

    rst  = 1'b0;
    din8 = 8'hFF;
    din5 = 5'h1F;
    model_flush();
    #1;
    check("reset_out8m", 32'(out8m), 32'd0);
    check("reset_out8l", 32'(out8l), 32'd0);
    check("reset_out5", 32'(out5), 32'd0);

    // Reset held over many edges with toggling data: everything stays at zero.
    for (int i = 0; i < 6; i++) begin
      din8 = ~din8;
      din5 = ~din5;
      tick();
      check("held_rst_cnt8", 32'(dut8m.cnt), 32'd0);
      check("held_rst_cnt5", 32'(dut5.cnt), 32'd0);
    end

    // Release between edges; the first edge afterwards is a frame start.
    #2 rst = 1'b1;
    din5 = 5'b10110;

    // Table-driven frames, 8-bit instances checked against constant bit sequences.
    foreach (vecs[v]) begin
      din8 = vecs[v].din;
      for (int b = 0; b < 8; b++) begin
        tick();
        sq = vecs[v].seq_msb;
        check("table_msb", 32'(out8m), 32'(sq[7-b]));
        sq = vecs[v].seq_lsb;
        check("table_lsb", 32'(out8l), 32'(sq[7-b]));
      end
    end

    // Mid-frame data change at edge 3: the current frame is unaffected, the next uses the new word.
    din8  = 8'b10011101;
    seq16 = 16'b10011101_10111101;
    for (int b = 0; b < 16; b++) begin
      tick();
      if (b == 2) din8 = 8'b10111101;
      check("midframe_change", 32'(out8m), 32'(seq16[15-b]));
    end

    // Reset during bit 4 of a frame aborts it; a fresh frame starts after release.
    din8 = 8'b11001010;
    for (int b = 0; b < 5; b++) tick();
    async_reset_pulse();
    din8 = 8'b01101001;
    for (int b = 0; b < 8; b++) begin
      tick();
      sq = 8'b01101001;
      check("post_rst_frame", 32'(out8m), 32'(sq[7-b]));
    end

    // WIDTH=5 scenario: 5'b10110 repeating with period 5.
    for (int i = 0; i < 20; i++) tick();

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) din8 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) din5 = 5'($urandom);
      if ($urandom_range(0, 49) == 0) async_reset_pulse();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
